// File: rtl/vx_dispatch_mat_seq_pkg.sv
// -----------------------------------------------------------------------------
// vx_dispatch_mat_seq_pkg
// Shared constants for the matrix dispatch sequencer: the dispatch payload
// field layout (so the m_type / m_row_size positions are defined once), the
// FSM state encodings and the row-count rule used when an instruction is
// latched.
// -----------------------------------------------------------------------------
package vx_dispatch_mat_seq_pkg;

  // Width of the m_type field inside the packed dispatch payload.
  localparam int M_TYPE_BITS     = 3;

  // Field offsets inside the packed dispatch payload.
  localparam int M_ROW_SIZE_LSB  = 0;
  localparam int M_ROW_SIZE_BITS = 4;
  localparam int M_TYPE_LSB      = 4;

  // Row counter width: one bit wider than m_row_size so a count of 15 and
  // the terminal compare never overflow.
  localparam int ROW_W           = M_ROW_SIZE_BITS + 1;

  // FSM encodings, kept as plain constants for compatibility with existing
  // consumers of the state value.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  // Number of micro-ops an instruction expands into. Non-matrix packets and
  // zero-row matrix packets still occupy exactly one issue slot.
  function automatic logic [ROW_W-1:0] calc_row_cnt(
    input logic [M_ROW_SIZE_BITS-1:0] m_row_size,
    input logic [M_TYPE_BITS-1:0]     m_type
  );
    if (m_type == '0 || m_row_size == '0) return ROW_W'(1);
    return {1'b0, m_row_size};
  endfunction

endpackage

// File: rtl/vx_dispatch_mat_seq_rr_grant.sv
// -----------------------------------------------------------------------------
// vx_rr_grant
// Combinational round-robin priority picker. Starting at index ptr and
// moving cyclically upward, the first asserted valid bit wins.
//
// Ports:
//   valid       in  NUM_REQS  request vector
//   ptr         in  SEL_W     highest-priority index this cycle (< NUM_REQS)
//   grant       out SEL_W     index of the winning request
//   grant_valid out 1         at least one request is asserted
// -----------------------------------------------------------------------------
module vx_rr_grant #(
  parameter int NUM_REQS = 4,
  parameter int SEL_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic [NUM_REQS-1:0] valid,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    grant,
  output logic                grant_valid
);

  int idx;

  // Scan from the farthest offset down to offset 0 so the candidate closest
  // to ptr is written last and therefore wins.
  // NOTE: every output gets a default before the loop; without it the
  // no-request path would hold the previous value and infer a latch.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_REQS;
      if (valid[idx]) begin
        grant       = SEL_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_dispatch_mat_seq.sv
// -----------------------------------------------------------------------------
// vx_dispatch_mat_seq
// Shares one matrix/tensor execution unit between NUM_REQS dispatch streams.
// In IDLE a round-robin arbiter picks one pending stream; its payload is
// latched and expanded into row micro-ops issued in order while in ISSUE.
// Non-matrix packets (m_type == 0) pass through as a single micro-op.
//
// Ports:
//   clk        in  1                 clock
//   reset      in  1                 synchronous active-high reset
//   req_valid  in  NUM_REQS          per-stream dispatch valid
//   req_data   in  NUM_REQS*DATA_W   per-stream payload, stream i at [i*DATA_W +: DATA_W]
//   req_ready  out NUM_REQS          per-stream accept (one-hot, IDLE only)
//   uop_valid  out 1                 micro-op valid to the unit
//   uop_data   out DATA_W            latched payload of the current instruction
//   uop_row    out 4                 row index of this micro-op
//   uop_last   out 1                 final micro-op of the instruction
//   uop_sel    out REQ_SEL_W         stream that owns the current instruction
//   uop_ready  in  1                 unit accepts the micro-op
//   busy       out 1                 an instruction is held (state ISSUE)
// -----------------------------------------------------------------------------
module vx_dispatch_mat_seq
  import vx_dispatch_mat_seq_pkg::*;
#(
  parameter int NUM_REQS  = 4,
  parameter int DATA_W    = 32,
  parameter int REQ_SEL_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQS-1:0]        req_valid,
  input  logic [NUM_REQS*DATA_W-1:0] req_data,
  output logic [NUM_REQS-1:0]        req_ready,
  output logic                       uop_valid,
  output logic [DATA_W-1:0]          uop_data,
  output logic [3:0]                 uop_row,
  output logic                       uop_last,
  output logic [REQ_SEL_W-1:0]       uop_sel,
  input  logic                       uop_ready,
  output logic                       busy
);

  logic [0:0]           state_r;
  logic [REQ_SEL_W-1:0] rr_ptr_r;
  logic [REQ_SEL_W-1:0] sel_r;
  logic [DATA_W-1:0]    data_r;
  logic [ROW_W-1:0]     row_r;
  logic [ROW_W-1:0]     row_cnt_r;

  logic [REQ_SEL_W-1:0] grant;
  logic                 grant_valid;
  logic [DATA_W-1:0]    grant_data;
  logic                 in_issue;
  logic                 accept;
  logic                 fire;

  vx_rr_grant #(
    .NUM_REQS (NUM_REQS),
    .SEL_W    (REQ_SEL_W)
  ) u_rr_grant (
    .valid       (req_valid),
    .ptr         (rr_ptr_r),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign grant_data = req_data[int'(grant)*DATA_W +: DATA_W];
  assign in_issue   = (state_r == ST_ISSUE);

  // Reset gates the handshakes combinationally so nothing is accepted or
  // issued during the reset cycle itself, including a reset mid-ISSUE.
  assign accept     = (state_r == ST_IDLE) && grant_valid && !reset;
  assign uop_valid  = in_issue && !reset;
  assign uop_last   = uop_valid && (row_r == row_cnt_r - ROW_W'(1));
  assign fire       = uop_valid && uop_ready;

  assign uop_data   = data_r;
  assign uop_row    = row_r[3:0];
  assign uop_sel    = sel_r;
  assign busy       = in_issue;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  // NOTE: the payload latch is reset too, so a discarded instruction never
  // reappears on uop_data after a mid-ISSUE reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      rr_ptr_r  <= '0;
      sel_r     <= '0;
      data_r    <= '0;
      row_r     <= '0;
      row_cnt_r <= ROW_W'(1);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept) begin
            data_r    <= grant_data;
            sel_r     <= grant;
            row_r     <= '0;
            row_cnt_r <= calc_row_cnt(grant_data[M_ROW_SIZE_LSB +: M_ROW_SIZE_BITS],
                                      grant_data[M_TYPE_LSB +: M_TYPE_BITS]);
            rr_ptr_r  <= (int'(grant) == NUM_REQS - 1) ? '0 : grant + 1'b1;
            state_r   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (fire) begin
            if (uop_last) state_r <= ST_IDLE;
            else          row_r   <= row_r + ROW_W'(1);
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vx_dispatch_mat_seq.sv
// -----------------------------------------------------------------------------
// tb_vx_dispatch_mat_seq
// Self-checking bench: scenario tasks push the micro-ops they expect into a
// scoreboard as they drive requests; a monitor pops and compares on every
// accepted micro-op. Tasks also make their own inline protocol comparisons.
// -----------------------------------------------------------------------------
module tb_vx_dispatch_mat_seq;

  localparam int NUM_REQS = 4;
  localparam int DATA_W   = 32;
  localparam int SEL_W    = 2;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [NUM_REQS-1:0]        req_valid;
  logic [NUM_REQS*DATA_W-1:0] req_data;
  logic [NUM_REQS-1:0]        req_ready;
  logic                       uop_valid;
  logic [DATA_W-1:0]          uop_data;
  logic [3:0]                 uop_row;
  logic                       uop_last;
  logic [SEL_W-1:0]           uop_sel;
  logic                       uop_ready;
  logic                       busy;

  int compared = 0;
  int errors   = 0;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [3:0]        row;
    logic              last;
    logic [SEL_W-1:0]  sel;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  vx_dispatch_mat_seq #(
    .NUM_REQS  (NUM_REQS),
    .DATA_W    (DATA_W),
    .REQ_SEL_W (SEL_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .uop_valid (uop_valid),
    .uop_data  (uop_data),
    .uop_row   (uop_row),
    .uop_last  (uop_last),
    .uop_sel   (uop_sel),
    .uop_ready (uop_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every accepted micro-op must match the oldest entry.
  always @(negedge clk) begin
    if (!reset && uop_valid && uop_ready) begin
      compared++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_uop: got data=%h row=%0d last=%0b sel=%0d, required none",
                 uop_data, uop_row, uop_last, uop_sel);
      end else begin
        mon_e = sb.pop_front();
        if (uop_data !== mon_e.data || uop_row !== mon_e.row ||
            uop_last !== mon_e.last || uop_sel !== mon_e.sel) begin
          errors++;
          $display("FAIL uop: got data=%h row=%0d last=%0b sel=%0d, required data=%h row=%0d last=%0b sel=%0d",
                   uop_data, uop_row, uop_last, uop_sel,
                   mon_e.data, mon_e.row, mon_e.last, mon_e.sel);
        end
      end
    end
  end

  function automatic logic [DATA_W-1:0] mk(input logic [24:0] tag, input logic [2:0] mt,
                                           input logic [3:0] rows);
    return {tag, mt, rows};
  endfunction

  // Expected expansion of one instruction, optionally truncated to 'limit'.
  task automatic push_instr(input int s, input logic [DATA_W-1:0] d, input int limit);
    int   n;
    exp_t e;
    n = (d[6:4] == 3'd0 || d[3:0] == 4'd0) ? 1 : int'(d[3:0]);
    for (int r = 0; r < n && r < limit; r++) begin
      e.data = d;
      e.row  = 4'(r);
      e.last = (r == n - 1);
      e.sel  = SEL_W'(s);
      sb.push_back(e);
    end
  endtask

  // Present a request and hold it until accepted; returns just after the
  // accepting edge (the first ISSUE cycle).
  task automatic send(input int s, input logic [DATA_W-1:0] d);
    int waited;
    req_data[s*DATA_W +: DATA_W] = d;
    req_valid[s] = 1'b1;
    waited = 0;
    @(negedge clk);
    while (req_ready[s] !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    compared++;
    if (req_ready[s] !== 1'b1) begin
      errors++;
      $display("FAIL grant_timeout: stream %0d req_ready=%b, required bit set", s, req_ready);
    end
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(posedge clk); #2;
    end
    compared++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d expected micro-ops outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    req_valid = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++;
    if (uop_valid !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b0 || uop_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: uop_valid=%b req_ready=%b busy=%b uop_last=%b, required 0 0000 0 0",
               uop_valid, req_ready, busy, uop_last);
    end
    @(posedge clk); #1;
    reset     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    compared++;
    if (uop_valid !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: uop_valid=%b req_ready=%b busy=%b, required 0 0000 0",
               uop_valid, req_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  // All four streams valid from rr_ptr = 0: grants 0,1,2,3,0 with one issue
  // cycle between consecutive grants.
  task automatic test_fairness;
    logic [DATA_W-1:0] d [NUM_REQS];
    int order [5] = '{0, 1, 2, 3, 0};
    int waited;
    for (int s = 0; s < NUM_REQS; s++) begin
      d[s] = mk(25'(32'h100 + s), 3'd1, 4'd1);
      req_data[s*DATA_W +: DATA_W] = d[s];
    end
    for (int k = 0; k < 5; k++) push_instr(order[k], d[order[k]], 16);
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      waited = 0;
      @(negedge clk);
      while (req_ready === 4'b0000 && waited < 8) begin
        @(negedge clk);
        waited++;
      end
      compared++;
      if (req_ready !== 4'(1 << order[k])) begin
        errors++;
        $display("FAIL rr_grant%0d: req_ready=%b, required %b", k, req_ready, 4'(1 << order[k]));
      end
      if (k > 0) begin
        compared++;
        if (waited != 1) begin
          errors++;
          $display("FAIL rr_spacing%0d: %0d idle cycles between grants, required 1", k, waited);
        end
      end
      @(posedge clk); #1;
      if (k == 4) req_valid = '0;
    end
    wait_drain("fairness");
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    logic [DATA_W-1:0] d;
    d = mk(25'h0ABCDE, 3'd1, 4'd4);
    push_instr(0, d, 16);
    req_data[0 +: DATA_W] = d;
    req_valid[0] = 1'b1;
    @(negedge clk);
    compared++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_accept: req_ready=%b, required 0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      compared++;
      if (uop_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL single_issue%0d: uop_valid=%b busy=%b req_ready=%b, required 1 1 0000",
                 r, uop_valid, busy, req_ready);
      end
    end
    @(negedge clk);
    compared++;
    if (uop_valid !== 1'b0 || busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL single_done: uop_valid=%b busy=%b pending=%0d, required 0 0 0",
               uop_valid, busy, sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_passthru;
    logic [DATA_W-1:0] d;
    d = mk(25'h1234567, 3'd0, 4'd7);
    push_instr(1, d, 16);
    send(1, d);
    wait_drain("passthru");
    @(negedge clk);
    compared++;
    if (uop_valid !== 1'b0) begin
      errors++;
      $display("FAIL passthru_single: uop_valid=%b after one micro-op, required 0", uop_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_rows;
    logic [DATA_W-1:0] d;
    d = mk(25'h0F0F0F0, 3'd2, 4'd0);
    push_instr(2, d, 16);
    send(2, d);
    wait_drain("zero_rows");
    @(negedge clk);
    compared++;
    if (uop_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_rows_single: uop_valid=%b after one micro-op, required 0", uop_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    logic [DATA_W-1:0] d;
    logic rdy [5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int   rows [5] = '{0, 1, 1, 1, 2};
    d = mk(25'h1555555, 3'd1, 4'd3);
    push_instr(1, d, 16);
    send(1, d);
    for (int i = 0; i < 5; i++) begin
      uop_ready = rdy[i];
      @(negedge clk);
      compared++;
      if (uop_valid !== 1'b1 || uop_row !== 4'(rows[i]) || uop_data !== d) begin
        errors++;
        $display("FAIL bp_cycle%0d: valid=%b row=%0d data=%h, required 1 %0d %h",
                 i, uop_valid, uop_row, uop_data, rows[i], d);
      end
      @(posedge clk); #1;
    end
    uop_ready = 1'b1;
    @(negedge clk);
    compared++;
    if (uop_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_done: uop_valid=%b pending=%0d, required 0 0", uop_valid, sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_issue;
    logic [DATA_W-1:0] d, d0, d3;
    d  = mk(25'h0AAAAAA, 3'd1, 4'd5);
    push_instr(2, d, 2);
    send(2, d);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if (uop_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_gate: uop_valid=%b during reset, required 0", uop_valid);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (uop_valid !== 1'b0 || busy !== 1'b0 || uop_last !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_after: uop_valid=%b busy=%b uop_last=%b pending=%0d, required 0 0 0 0",
               uop_valid, busy, uop_last, sb.size());
    end
    @(posedge clk); #1;
    // rr_ptr is back at 0, so stream 0 must win over stream 3.
    d0 = mk(25'h0000011, 3'd1, 4'd1);
    d3 = mk(25'h0000033, 3'd3, 4'd2);
    push_instr(0, d0, 16);
    push_instr(3, d3, 16);
    req_data[0 +: DATA_W]        = d0;
    req_data[3*DATA_W +: DATA_W] = d3;
    req_valid = 4'b1001;
    @(negedge clk);
    compared++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL mid_reset_rr: req_ready=%b, required 0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    send(3, d3);
    wait_drain("mid_reset");
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    uop_ready = 1'b1;
    test_reset();
    test_fairness();
    test_single();
    test_passthru();
    test_zero_rows();
    test_backpressure();
    test_reset_mid_issue();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end

endmodule
